branch_unit: RTL and testbench
==============================

// Module: branch_unit
// PURPOSE
//  Sequential branch-control unit for the LEGv8 datapath. Successor to the single-cycle BR decoder.
//  Accepts one branch instruction through a valid/ready handshake and covers B, BL, BR, CBZ, CBNZ and B.cond.
//  Issues a multi-cycle sequence of control words (link write, zero test, PC update) on the shared datapath.
//  Sits beside the other instruction-class decoders; the top-level control mux selects its controlWord while busy=1.
// PARAMETERS
//  DATA_WIDTH  64        width of K and of sign-extended offsets
//  LINK_REG    5'd30     DA used by BL for the return-address write
//  FSEL_PASS_B 5'b00100  Fsel that gives A|B; with SA=XZR the ALU passes B through (CBZ/CBNZ test)
//  ENABLE_COND 1         1: B.cond is supported; 0: B.cond is decoded as unsupported
// PORTS
//  clock        in   1           rising-edge clock
//  reset        in   1           synchronous, active-high
//  instr_valid  in   1           instruction is present
//  instr_ready  out  1           unit can accept (high only in IDLE)
//  instruction  in   32          instruction word, sampled on accept
//  flags        in   4           {N,Z,C,V}, sampled on accept
//  alu_zero     in   1           ALU zero flag, sampled at the end of EVAL
//  controlWord  out  31          {Psel[1:0],DA,SA,SB,Fsel,regW,ramW,EN_MEM,EN_ALU,EN_B,EN_PC,Bsel,PCsel,SL}
//  K            out  DATA_WIDTH  sign-extended word offset (imm26 or imm19)
//  busy         out  1           unit is outside IDLE
//  done         out  1           one-cycle pulse in the PC-update (JUMP) cycle
//  taken        out  1           branch taken; valid only while done=1
//  error        out  1           unsupported opcode; valid only while done=1
// BEHAVIOUR
//  Reset (synchronous, wins over everything): state=IDLE, controlWord=IDLE_CW, K=0, done=taken=error=0.
//   Mid-sequence reset aborts the sequence; no regW or PC write occurs after the reset edge.
//  IDLE_CW: Psel=00 (hold), DA=SA=SB=5'b11111, Fsel=0, all enables/strobes 0.
//  Psel encoding: 00 hold; 01 PC<-PC+4; 10 PC<-bus (A path when PCsel=0); 11 PC<-PC+(K<<2).
//  Accept: instr_valid & instr_ready at a rising edge latches instruction and flags.
//   instr_valid is ignored while busy.
//  Decode (of the latched word) and next state:
//   B     [31:26]=000101     imm26 -> JUMP
//   BL    [31:26]=100101     imm26 -> LINK
//   BR    [31:21]=11010110000, Rn=[9:5] -> JUMP
//   CBZ   [31:24]=10110100, CBNZ [31:24]=10110101, imm19=[23:5], Rt=[4:0] -> EVAL
//   B.cond [31:24]=01010100, imm19, cond=[3:0] -> JUMP
//   anything else -> JUMP with error=1
//  FSM states: IDLE, EVAL, LINK, JUMP. JUMP always returns to IDLE.
//  EVAL (1 cycle): SA=31, SB=Rt, Fsel=FSEL_PASS_B, Bsel=0, Psel=00, EN_ALU=1.
//   At the end of EVAL, taken_r <= alu_zero (CBZ) or ~alu_zero (CBNZ).
//  LINK (1 cycle): DA=LINK_REG, regW=1, EN_PC=1 (PC+4 onto the bus), Psel=00.
//  JUMP (1 cycle): done=1, taken valid, error valid.
//   taken=1, BR: Psel=10, SA=Rn, PCsel=0.
//   taken=1, all other branches: Psel=11, PCsel=1.
//   taken=0 (including error=1): Psel=01.
//   regW=ramW=0 in JUMP.
//  Taken rules: B, BL, BR are always taken. CBZ/CBNZ use taken_r.
//   B.cond uses the latched flags: EQ Z, NE !Z, HS C, LO !C, MI N, PL !N, VS V, VC !V,
//   HI C&!Z, LS !(C&!Z), GE N==V, LT N!=V, GT !Z&(N==V), LE !(!Z&(N==V)), 1110/1111 always.
//  K: SignExt(imm26) for B/BL; SignExt(imm19) for CBZ/CBNZ/B.cond; 0 for BR and unsupported.
//   K is held stable from the cycle after accept through JUMP.
//  Latency (accept edge = cycle N):
//   B/BR/B.cond: JUMP at N+1, ready again at N+2.
//   BL/CBZ/CBNZ: JUMP at N+2, ready again at N+3.
//  Outputs are registered: controlWord is a function of the state and the latched instruction only.
// TESTING
//  B, imm26=26'h3FFFFFF -> cycle N+1: done=1, taken=1, Psel=11, PCsel=1, K=-1; instr_ready=1 at N+2.
//  BL, imm26=5 -> N+1: DA=30, regW=1, EN_PC=1; N+2: Psel=11, K=5, regW=0, done=1.
//  CBZ X3 with alu_zero=1 at end of EVAL -> EVAL shows SB=3, SA=31; JUMP taken=1, Psel=11.
//   CBNZ with the same zero -> taken=0, Psel=01.
//  B.GT with flags {N,Z,C,V}=1001 -> taken=1; flags=0100 -> taken=0, Psel=01.
//   Check all 16 condition codes.
//  BR X7 -> N+1: Psel=10, SA=7, PCsel=0, K=0, done=1.
//   Unsupported word 32'h0 -> N+1: error=1, taken=0, Psel=01.
//  Reset asserted during LINK of BL -> next cycle IDLE_CW, done=0, no JUMP.
//   instr_valid held high while busy -> no second accept until instr_ready.

Source files
------------

// File: rtl/branch_unit.sv
// branch_unit: sequential branch-control unit for the LEGv8 datapath.
// Accepts one branch instruction (B, BL, BR, CBZ, CBNZ, B.cond) through a
// valid/ready handshake and sequences the control words it needs on the
// shared datapath. The states are EVAL (zero test), LINK (return-address
// write) and JUMP (PC update).
//
// Handshake: an instruction is accepted on a rising edge where
// instr_valid & instr_ready. instr_ready is high only in IDLE. instr_valid
// is ignored while busy. The producer holds instruction/flags stable while
// instr_valid is high and not yet accepted.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   instr_valid/ready instruction handshake
//   instruction       32-bit instruction word, latched on accept
//   flags             {N,Z,C,V}, latched on accept
//   alu_zero          ALU zero flag, sampled at the end of EVAL
//   controlWord       {Psel,DA,SA,SB,Fsel,regW,ramW,EN_MEM,EN_ALU,EN_B,
//                      EN_PC,Bsel,PCsel,SL}, registered
//   K                 sign-extended word offset, registered
//   busy              unit is outside IDLE
//   done              one-cycle pulse in the JUMP cycle
//   taken, error      branch outcome / unsupported opcode, valid with done
//   dbg_state         current FSM state (0 IDLE, 1 EVAL, 2 LINK, 3 JUMP)
module branch_unit #(
    parameter int          DATA_WIDTH  = 64,
    parameter logic [4:0]  LINK_REG    = 5'd30,
    parameter logic [4:0]  FSEL_PASS_B = 5'b00100,
    parameter bit          ENABLE_COND = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instruction,
    input  logic [3:0]            flags,
    input  logic                  alu_zero,
    output logic [30:0]           controlWord,
    output logic [DATA_WIDTH-1:0] K,
    output logic                  busy,
    output logic                  done,
    output logic                  taken,
    output logic                  error,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_LINK, S_JUMP} state_t;
    typedef enum logic [2:0] {K_B, K_BL, K_BR, K_CBZ, K_CBNZ, K_BCOND, K_BAD} kind_t;

    localparam logic [30:0] IDLE_CW = {2'b00, 5'd31, 5'd31, 5'd31, 5'd0, 9'd0};

    state_t                state_q, state_d;
    logic [31:0]           instr_q, instr_d;
    logic [3:0]            flags_q, flags_d;
    logic                  taken_r_q, taken_r_d;
    logic [30:0]           cw_q, cw_d;
    logic [DATA_WIDTH-1:0] k_q, k_d;
    logic                  done_q, done_d;
    logic                  taken_q, taken_d;
    logic                  error_q, error_d;

    logic                  accept;
    kind_t                 kind;
    logic                  cond_true;
    logic [1:0]            psel;
    logic [4:0]            da, sa, sb, fsel;
    logic                  reg_w, en_alu, en_pc, pcsel;

    // Condition codes: bits [3:1] select the base test, bit 0 inverts it
    // (except 111x, which is always true).
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c[3:1])
            3'b000:  base = z;
            3'b001:  base = cf;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = cf & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (c[0] && c[3:1] != 3'b111) ? ~base : base;
    endfunction

    always_comb begin
        accept  = instr_valid & (state_q == S_IDLE);
        // Outputs are registered, so decode works on the word that will be
        // latched: the incoming one on accept, the held one otherwise.
        instr_d = accept ? instruction : instr_q;
        flags_d = accept ? flags : flags_q;

        if (instr_d[31:26] == 6'b000101)                       kind = K_B;
        else if (instr_d[31:26] == 6'b100101)                  kind = K_BL;
        else if (instr_d[31:21] == 11'b11010110000)            kind = K_BR;
        else if (instr_d[31:24] == 8'b10110100)                kind = K_CBZ;
        else if (instr_d[31:24] == 8'b10110101)                kind = K_CBNZ;
        else if (ENABLE_COND && instr_d[31:24] == 8'b01010100) kind = K_BCOND;
        else                                                   kind = K_BAD;

        cond_true = cond_eval(instr_d[3:0], flags_d);

        state_d   = state_q;
        taken_r_d = taken_r_q;
        case (state_q)
            S_IDLE: if (accept) begin
                case (kind)
                    K_BL:           state_d = S_LINK;
                    K_CBZ, K_CBNZ:  state_d = S_EVAL;
                    default:        state_d = S_JUMP;
                endcase
                case (kind)
                    K_B, K_BL, K_BR: taken_r_d = 1'b1;
                    K_BCOND:         taken_r_d = cond_true;
                    default:         taken_r_d = 1'b0;
                endcase
            end
            S_EVAL: begin
                state_d   = S_JUMP;
                taken_r_d = (kind == K_CBNZ) ? ~alu_zero : alu_zero;
            end
            S_LINK:  state_d = S_JUMP;
            default: state_d = S_IDLE;
        endcase

        psel   = 2'b00;
        da     = 5'd31;
        sa     = 5'd31;
        sb     = 5'd31;
        fsel   = 5'd0;
        reg_w  = 1'b0;
        en_alu = 1'b0;
        en_pc  = 1'b0;
        pcsel  = 1'b0;
        case (state_d)
            S_EVAL: begin
                // SA=XZR with A|B passes Rt through the ALU for the zero test.
                sb     = instr_d[4:0];
                fsel   = FSEL_PASS_B;
                en_alu = 1'b1;
            end
            S_LINK: begin
                da    = LINK_REG;
                reg_w = 1'b1;
                en_pc = 1'b1;
            end
            S_JUMP: begin
                if (!taken_r_d) begin
                    psel = 2'b01;
                end else if (kind == K_BR) begin
                    psel = 2'b10;
                    sa   = instr_d[9:5];
                end else begin
                    psel  = 2'b11;
                    pcsel = 1'b1;
                end
            end
            default: ;
        endcase
        cw_d = {psel, da, sa, sb, fsel, reg_w, 1'b0, 1'b0, en_alu, 1'b0, en_pc, 1'b0, pcsel, 1'b0};

        k_d = '0;
        if (state_d != S_IDLE) begin
            case (kind)
                K_B, K_BL:                 k_d = {{(DATA_WIDTH-26){instr_d[25]}}, instr_d[25:0]};
                K_CBZ, K_CBNZ, K_BCOND:    k_d = {{(DATA_WIDTH-19){instr_d[23]}}, instr_d[23:5]};
                default:                   k_d = '0;
            endcase
        end

        done_d  = (state_d == S_JUMP);
        taken_d = done_d & taken_r_d;
        error_d = done_d & (kind == K_BAD);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            flags_q   <= '0;
            taken_r_q <= 1'b0;
            cw_q      <= IDLE_CW;
            k_q       <= '0;
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            flags_q   <= flags_d;
            taken_r_q <= taken_r_d;
            cw_q      <= cw_d;
            k_q       <= k_d;
            done_q    <= done_d;
            taken_q   <= taken_d;
            error_q   <= error_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign controlWord = cw_q;
    assign K           = k_q;
    assign done        = done_q;
    assign taken       = taken_q;
    assign error       = error_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: table of branch vectors with hand-computed
// outcomes, plus hand-written sequences for reset abort and held valid.
module tb_branch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [3:0]  flags;
    logic        alu_zero;
    logic [30:0] controlWord;
    logic [63:0] K;
    logic        busy, done, taken, error;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    localparam logic [30:0] IDLE_CW = {2'b00, 5'd31, 5'd31, 5'd31, 5'd0, 9'd0};

    // kind: 0 = direct JUMP, 1 = LINK first, 2 = EVAL first
    typedef struct {
        logic [31:0] instr;
        logic [3:0]  flg;
        logic        az;
        int          kind;
        logic [4:0]  exp_sb;
        logic        exp_taken;
        logic        exp_error;
        logic [1:0]  exp_psel;
        logic        exp_pcsel;
        logic [4:0]  exp_sa;
        logic [63:0] exp_k;
    } vec_t;

    vec_t vecs[$];

    branch_unit dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .flags(flags), .alu_zero(alu_zero),
        .controlWord(controlWord), .K(K), .busy(busy), .done(done), .taken(taken),
        .error(error), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] i, input logic [3:0] f, input logic az, input int kind,
                       input logic [4:0] sb, input logic tk, input logic er, input logic [1:0] ps,
                       input logic pc, input logic [4:0] sa, input logic [63:0] k);
        vec_t v;
        v.instr = i; v.flg = f; v.az = az; v.kind = kind; v.exp_sb = sb;
        v.exp_taken = tk; v.exp_error = er; v.exp_psel = ps; v.exp_pcsel = pc;
        v.exp_sa = sa; v.exp_k = k;
        vecs.push_back(v);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("ready_timeout", {63'd0, instr_ready}, 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("v%0d", idx);
        instruction = v.instr;
        flags       = v.flg;
        alu_zero    = v.az;
        instr_valid = 1'b1;
        @(posedge clock);
        #1 instr_valid = 1'b0;
        instruction = 32'hDEADBEEF;   // latched copy must be used from here on
        flags       = ~v.flg;
        @(negedge clock);
        if (v.kind != 0) begin
            chk({s, "_mid_done"}, {63'd0, done}, 64'd0);
            chk({s, "_mid_ready"}, {63'd0, instr_ready}, 64'd0);
            if (v.kind == 1) begin
                chk({s, "_link_da"}, {59'd0, controlWord[28:24]}, 64'd30);
                chk({s, "_link_regw_enpc"}, {62'd0, controlWord[8], controlWord[3]}, 64'd3);
                chk({s, "_link_psel"}, {62'd0, controlWord[30:29]}, 64'd0);
            end else begin
                chk({s, "_eval_sa"}, {59'd0, controlWord[23:19]}, 64'd31);
                chk({s, "_eval_sb"}, {59'd0, controlWord[18:14]}, {59'd0, v.exp_sb});
                chk({s, "_eval_fsel"}, {59'd0, controlWord[13:9]}, 64'd4);
                chk({s, "_eval_enalu"}, {63'd0, controlWord[5]}, 64'd1);
            end
            @(negedge clock);
        end
        chk({s, "_done"}, {63'd0, done}, 64'd1);
        chk({s, "_taken"}, {63'd0, taken}, {63'd0, v.exp_taken});
        chk({s, "_error"}, {63'd0, error}, {63'd0, v.exp_error});
        chk({s, "_psel"}, {62'd0, controlWord[30:29]}, {62'd0, v.exp_psel});
        chk({s, "_pcsel"}, {63'd0, controlWord[1]}, {63'd0, v.exp_pcsel});
        chk({s, "_sa"}, {59'd0, controlWord[23:19]}, {59'd0, v.exp_sa});
        chk({s, "_regw"}, {63'd0, controlWord[8]}, 64'd0);
        chk({s, "_k"}, K, v.exp_k);
        @(negedge clock);
        chk({s, "_ready_after"}, {63'd0, instr_ready}, 64'd1);
        chk({s, "_done_after"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [15:0] exp_1001, exp_0110;
        exp_1001 = 16'hD65A;   // condition results for N=1 Z=0 C=0 V=1, bit i = cond i
        exp_0110 = 16'hE6A5;   // condition results for N=0 Z=1 C=1 V=0

        add(32'h17FFFFFF, 4'h0, 1'b0, 0, 5'd0, 1, 0, 2'b11, 1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF); // B -1
        add(32'h94000005, 4'h0, 1'b0, 1, 5'd0, 1, 0, 2'b11, 1, 5'd31, 64'd5);                   // BL 5
        add(32'hB4000083, 4'h0, 1'b1, 2, 5'd3, 1, 0, 2'b11, 1, 5'd31, 64'd4);                   // CBZ X3 zero
        add(32'hB5000083, 4'h0, 1'b1, 2, 5'd3, 0, 0, 2'b01, 0, 5'd31, 64'd4);                   // CBNZ X3 zero
        add(32'hB4FFFFE3, 4'h0, 1'b0, 2, 5'd3, 0, 0, 2'b01, 0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF); // CBZ nonzero
        add(32'hB50000A9, 4'h0, 1'b0, 2, 5'd9, 1, 0, 2'b11, 1, 5'd31, 64'd5);                   // CBNZ X9 nonzero
        add(32'hD61F00E0, 4'h0, 1'b0, 0, 5'd0, 1, 0, 2'b10, 0, 5'd7, 64'd0);                    // BR X7
        add(32'h00000000, 4'h0, 1'b0, 0, 5'd0, 0, 1, 2'b01, 0, 5'd31, 64'd0);                   // unsupported
        add(32'h5400004C, 4'b0100, 1'b0, 0, 5'd0, 0, 0, 2'b01, 0, 5'd31, 64'd2);                // B.GT Z=1
        for (int c = 0; c < 16; c++) begin
            add(32'h54000040 | c, 4'b1001, 1'b0, 0, 5'd0, exp_1001[c], 0,
                exp_1001[c] ? 2'b11 : 2'b01, exp_1001[c], 5'd31, 64'd2);
            add(32'h54000040 | c, 4'b0110, 1'b0, 0, 5'd0, exp_0110[c], 0,
                exp_0110[c] ? 2'b11 : 2'b01, exp_0110[c], 5'd31, 64'd2);
        end

        reset = 1'b1; instr_valid = 1'b0; instruction = '0; flags = '0; alu_zero = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_cw", {33'd0, controlWord}, {33'd0, IDLE_CW});
        chk("rst_k", K, 64'd0);
        chk("rst_flags", {61'd0, done, taken, error}, 64'd0);
        chk("rst_ready_busy", {62'd0, instr_ready, busy}, 64'd2);

        foreach (vecs[i]) begin
            wait_ready();
            run_vec(vecs[i], i);
        end

        // Reset during LINK of BL aborts the sequence.
        wait_ready();
        instruction = 32'h94000005; instr_valid = 1'b1;
        @(posedge clock);
        #1 instr_valid = 1'b0;
        @(negedge clock);
        chk("abort_in_link", {63'd0, controlWord[8]}, 64'd1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("abort_cw", {33'd0, controlWord}, {33'd0, IDLE_CW});
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        @(negedge clock);
        chk("abort_no_jump", {63'd0, done}, 64'd0);

        // instr_valid held high while busy: no second accept until ready.
        wait_ready();
        instruction = 32'h14000003; instr_valid = 1'b1;
        @(negedge clock);
        chk("hold_n1_done", {63'd0, done}, 64'd1);
        chk("hold_n1_ready", {63'd0, instr_ready}, 64'd0);
        @(negedge clock);
        chk("hold_n2_done", {63'd0, done}, 64'd0);
        chk("hold_n2_ready", {63'd0, instr_ready}, 64'd1);
        @(posedge clock);
        #1 instr_valid = 1'b0;
        @(negedge clock);
        chk("hold_second_done", {63'd0, done}, 64'd1);
        chk("hold_second_k", K, 64'd3);
        @(negedge clock);
        chk("hold_final_idle", {62'd0, instr_ready, done}, 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
